and_result_buffer: RTL and testbench

- Stage directly downstream of the 8-bit bitwise AND unit.
- Captures each valid AND result into a small FIFO and presents it to the consumer over a valid/ready handshake.
- Decouples the free-running combinational producer from a consumer that may stall.
- Keeps sticky overflow status and a saturating count of dropped results for debug readout on the IO pins.

---
 rtl/and_pipe_pkg.sv | 16 +
 rtl/sat_counter.sv | 29 ++
 rtl/and_result_buffer.sv | 93 +++++++++
 tb/tb_and_result_buffer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/and_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : and_pipe_pkg
//  Brief    : Shared types and default sizes for the AND pipeline stages.
//  Revision : 1.0  initial release
// ============================================================================
package and_pipe_pkg;

  localparam int DATA_W    = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef logic [DATA_W-1:0] data_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Saturating up-counter; a clear wins over a concurrent increment.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count increments until all ones; clear has priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/and_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : and_result_buffer
//  Brief    : Show-ahead FIFO behind the AND unit, with sticky overflow flag
//             and a saturating count of results dropped while full.
//  Revision : 1.0  initial release
// ============================================================================
module and_result_buffer
  import and_pipe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  input  logic                     clr_stats,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  // Handshake decode; a pop while full frees the slot for a same-cycle push.
  always_comb begin
    out_valid = (level != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    in_ready  = (level != FULL_LEVEL) || out_ready;
    pop       = out_valid && out_ready;
    push      = in_valid && in_ready;
    drop      = in_valid && !in_ready;
  end

  // Storage write; contents need no reset since out_data is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally; occupancy is tracked separately in level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Sticky overflow flag; clear beats a concurrent drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clr_stats) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (drop),
    .count (drop_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_and_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_and_result_buffer
//  Brief    : Self-checking bench with a queue-based reference model. A second
//             instance with a 2-bit drop counter shares the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_and_result_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       clr_stats = 1'b0;

  logic       in_ready, out_valid, overflow;
  logic [7:0] out_data, drop_count;
  logic [2:0] level;
  logic       in_ready2, out_valid2, overflow2;
  logic [7:0] out_data2;
  logic [1:0] drop_count2;
  logic [2:0] level2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf;
  int         m_d8;
  int         m_d2;

  always #5 clk = ~clk;

  and_result_buffer #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .clr_stats(clr_stats), .level(level),
    .overflow(overflow), .drop_count(drop_count)
  );

  and_result_buffer #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .out_ready(out_ready), .clr_stats(clr_stats), .level(level2),
    .overflow(overflow2), .drop_count(drop_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every registered output against the model.
  task automatic check_state(input string where);
    logic [7:0] exp_data;
    exp_data = (q.size() != 0) ? q[0] : 8'h00;
    chk({where, ".level"},      32'(level),       32'(q.size()));
    chk({where, ".out_valid"},  32'(out_valid),   32'(q.size() != 0));
    chk({where, ".out_data"},   32'(out_data),    32'(exp_data));
    chk({where, ".overflow"},   32'(overflow),    32'(m_ovf));
    chk({where, ".drop_count"}, 32'(drop_count),  32'(m_d8));
    chk({where, ".out_data2"},  32'(out_data2),   32'(exp_data));
    chk({where, ".overflow2"},  32'(overflow2),   32'(m_ovf));
    chk({where, ".drop_cnt2"},  32'(drop_count2), 32'(m_d2));
  endtask

  // One clock cycle: drive, check in_ready, update model, check after edge.
  task automatic step(input string where, input bit iv, input logic [7:0] id,
                      input bit ordy, input bit clr);
    bit exp_rdy, pop, push, drop;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clr_stats = clr;
    #1;
    exp_rdy = (q.size() != DEPTH) || ordy;
    chk({where, ".in_ready"},  32'(in_ready),  32'(exp_rdy));
    chk({where, ".in_ready2"}, 32'(in_ready2), 32'(exp_rdy));
    pop  = (q.size() != 0) && ordy;
    push = iv && exp_rdy;
    drop = iv && !exp_rdy;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(id);
    if (clr) begin
      m_ovf = 0; m_d8 = 0; m_d2 = 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_d8 < 255) m_d8++;
      if (m_d2 < 3)   m_d2++;
    end
    @(posedge clk);
    #1;
    check_state(where);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_d8 = 0; m_d2 = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Three pushes with consumer stalled, then drain.
    step("p_a5", 1, 8'hA5, 0, 0);
    step("p_3c", 1, 8'h3C, 0, 0);
    step("p_ff", 1, 8'hFF, 0, 0);
    chk("three.level", 32'(level), 32'd3);
    repeat (4) step("drain3", 0, 8'h00, 1, 0);

    // Fill, then two results dropped while full, then drain.
    for (int i = 1; i <= 4; i++) step("fill", 1, 8'(i), 0, 0);
    step("drop55", 1, 8'h55, 0, 0);
    step("drop66", 1, 8'h66, 0, 0);
    chk("drop.count", 32'(drop_count), 32'd2);
    chk("drop.ovf",   32'(overflow),   32'd1);
    repeat (5) step("drain4", 0, 8'h00, 1, 0);

    // Full with simultaneous push/pop streaming across pointer wrap.
    for (int i = 1; i <= 4; i++) step("refill", 1, 8'(i), 0, 0);
    for (int i = 0; i < 8; i++) step("stream", 1, 8'(8'h10 + i), 1, 0);
    chk("stream.level", 32'(level), 32'd4);
    chk("stream.drops", 32'(drop_count), 32'd2);

    // Five more drops saturate the 2-bit counter; then clear with a drop.
    for (int i = 0; i < 5; i++) step("sat", 1, 8'(8'hC0 + i), 0, 0);
    chk("sat.cnt2", 32'(drop_count2), 32'd3);
    chk("sat.cnt8", 32'(drop_count),  32'd7);
    step("clr_drop", 1, 8'hEE, 0, 1);
    chk("clr.ovf", 32'(overflow), 32'd0);

    // Asynchronous reset at level 3, mid-cycle.
    repeat (5) step("pre_rst_drain", 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 8'(8'h90 + i), 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_state("async_rst");
    chk("async_rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    step("p_77", 1, 8'h77, 0, 0);
    chk("p77.data", 32'(out_data), 32'h77);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 8'($urandom),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
